// File: rtl/register_file_pkg.sv
// Shared types and constants for the architectural register file.
// Holds the register index, ROB id and data word types, their zero values,
// the boolean constants used by the read/update logic, and a small helper
// that tells whether a register index names a writable register (not x0).
package register_file_pkg;

  localparam int unsigned REG_NUM       = 32;
  localparam int unsigned REG_POS_WIDTH = 5;
  localparam int unsigned ROB_ID_WIDTH  = 5;
  localparam int unsigned DATA_WIDTH    = 32;

  typedef logic [REG_POS_WIDTH-1:0] reg_pos_t;
  typedef logic [ROB_ID_WIDTH-1:0]  rob_id_t;
  typedef logic [DATA_WIDTH-1:0]    data_t;

  localparam reg_pos_t ZERO_REG  = '0;
  localparam rob_id_t  ZERO_ROB  = '0;  // "no producer": value is ready
  localparam data_t    ZERO_WORD = '0;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // x0 is hardwired to zero and never carries a tag.
  function automatic logic is_arch_reg(input reg_pos_t pos);
    return (pos != ZERO_REG) ? TRUE : FALSE;
  endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file with rename tags.
// Each of the 32 registers holds a 32-bit value and a 5-bit ROB tag naming
// the in-flight instruction that will produce it (0 = value is ready).
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   rdy                            global ready; all state holds while low
//   rs1/rs2_from_dispatcher        source indices for the two read ports
//   V1/Q1, V2/Q2_to_dispatcher     combinational value and producer tag
//   rename_signal/rd/rob_id_*      tag rd with a newly allocated ROB id
//   commit_signal/rd/Q/V_from_rob  write back a committed result
//   misbranch_flag_from_rob        clear every outstanding tag
module register_file
  import register_file_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,

  input  logic [REG_POS_WIDTH-1:0] rs1_from_dispatcher,
  input  logic [REG_POS_WIDTH-1:0] rs2_from_dispatcher,
  output logic [DATA_WIDTH-1:0]    V1_to_dispatcher,
  output logic [ROB_ID_WIDTH-1:0]  Q1_to_dispatcher,
  output logic [DATA_WIDTH-1:0]    V2_to_dispatcher,
  output logic [ROB_ID_WIDTH-1:0]  Q2_to_dispatcher,

  input  logic                     rename_signal_from_dispatcher,
  input  logic [REG_POS_WIDTH-1:0] rd_from_dispatcher,
  input  logic [ROB_ID_WIDTH-1:0]  rob_id_from_dispatcher,

  input  logic                     commit_signal_from_rob,
  input  logic [REG_POS_WIDTH-1:0] rd_from_rob,
  input  logic [ROB_ID_WIDTH-1:0]  Q_from_rob,
  input  logic [DATA_WIDTH-1:0]    V_from_rob,

  input  logic                     misbranch_flag_from_rob
);

  data_t   value_q [REG_NUM];
  data_t   value_d [REG_NUM];
  rob_id_t tag_q   [REG_NUM];
  rob_id_t tag_d   [REG_NUM];

  logic commit_ok;
  logic rename_ok;

  assign commit_ok = commit_signal_from_rob && is_arch_reg(rd_from_rob);
  assign rename_ok = rename_signal_from_dispatcher && is_arch_reg(rd_from_dispatcher)
                     && !misbranch_flag_from_rob;

  // Next-state. Order matters: commit tag-clear first, then the flush, then
  // rename so a same-cycle rename overrides the commit's tag clear.
  always_comb begin
    for (int unsigned i = 0; i < REG_NUM; i++) begin
      value_d[i] = value_q[i];
      tag_d[i]   = tag_q[i];
    end

    if (commit_ok) begin
      // The value is written unconditionally; the tag is only released if no
      // younger instruction has renamed the register since.
      value_d[rd_from_rob] = V_from_rob;
      if (tag_q[rd_from_rob] == Q_from_rob) begin
        tag_d[rd_from_rob] = ZERO_ROB;
      end
    end

    if (misbranch_flag_from_rob) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        tag_d[i] = ZERO_ROB;
      end
    end

    if (rename_ok) begin
      tag_d[rd_from_dispatcher] = rob_id_from_dispatcher;
    end

    value_d[0] = ZERO_WORD;
    tag_d[0]   = ZERO_ROB;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        value_q[i] <= ZERO_WORD;
        tag_q[i]   <= ZERO_ROB;
      end
    end else if (rdy) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        value_q[i] <= value_d[i];
        tag_q[i]   <= tag_d[i];
      end
    end
  end

  // Read port 1. A commit retiring the current producer is forwarded so the
  // dispatcher sees the result in the same cycle it is written.
  always_comb begin
    V1_to_dispatcher = ZERO_WORD;
    Q1_to_dispatcher = ZERO_ROB;
    if (is_arch_reg(rs1_from_dispatcher)) begin
      if (commit_signal_from_rob && (rd_from_rob == rs1_from_dispatcher)
          && (tag_q[rs1_from_dispatcher] == Q_from_rob)) begin
        V1_to_dispatcher = V_from_rob;
      end else begin
        V1_to_dispatcher = value_q[rs1_from_dispatcher];
        Q1_to_dispatcher = tag_q[rs1_from_dispatcher];
      end
    end
  end

  // Read port 2, identical to port 1.
  always_comb begin
    V2_to_dispatcher = ZERO_WORD;
    Q2_to_dispatcher = ZERO_ROB;
    if (is_arch_reg(rs2_from_dispatcher)) begin
      if (commit_signal_from_rob && (rd_from_rob == rs2_from_dispatcher)
          && (tag_q[rs2_from_dispatcher] == Q_from_rob)) begin
        V2_to_dispatcher = V_from_rob;
      end else begin
        V2_to_dispatcher = value_q[rs2_from_dispatcher];
        Q2_to_dispatcher = tag_q[rs2_from_dispatcher];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: table of per-cycle vectors whose
// expected read-port values are the combinational outputs just before the
// clock edge, plus hand-written reset sequences.
module tb_register_file;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [4:0]  rs1, rs2;
  logic [31:0] v1, v2;
  logic [4:0]  q1, q2;
  logic        rename;
  logic [4:0]  rd_d;
  logic [4:0]  rob_id;
  logic        commit;
  logic [4:0]  rd_r;
  logic [4:0]  q_r;
  logic [31:0] v_r;
  logic        mis;

  int checks;
  int errors;

  register_file dut (
    .clk                           (clk),
    .rst                           (rst),
    .rdy                           (rdy),
    .rs1_from_dispatcher           (rs1),
    .rs2_from_dispatcher           (rs2),
    .V1_to_dispatcher              (v1),
    .Q1_to_dispatcher              (q1),
    .V2_to_dispatcher              (v2),
    .Q2_to_dispatcher              (q2),
    .rename_signal_from_dispatcher (rename),
    .rd_from_dispatcher            (rd_d),
    .rob_id_from_dispatcher        (rob_id),
    .commit_signal_from_rob        (commit),
    .rd_from_rob                   (rd_r),
    .Q_from_rob                    (q_r),
    .V_from_rob                    (v_r),
    .misbranch_flag_from_rob       (mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        ren;
    logic [4:0]  rd_d;
    logic [4:0]  rob_id;
    logic        com;
    logic [4:0]  rd_r;
    logic [4:0]  q_r;
    logic [31:0] v_r;
    logic        mis;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] ev1;
    logic [4:0]  eq1;
    logic [31:0] ev2;
    logic [4:0]  eq2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rdy_i, input logic ren_i, input logic [4:0] rdd,
                              input logic [4:0] rid, input logic com_i, input logic [4:0] rdr,
                              input logic [4:0] qr, input logic [31:0] vr, input logic mis_i,
                              input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] ev1, input logic [4:0] eq1,
                              input logic [31:0] ev2, input logic [4:0] eq2);
    vec_t v;
    v.rdy = rdy_i; v.ren = ren_i; v.rd_d = rdd; v.rob_id = rid;
    v.com = com_i; v.rd_r = rdr; v.q_r = qr; v.v_r = vr; v.mis = mis_i;
    v.rs1 = a1; v.rs2 = a2; v.ev1 = ev1; v.eq1 = eq1; v.ev2 = ev2; v.eq2 = eq2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rdy = 1'b1; rename = 1'b0; rd_d = '0; rob_id = '0;
    commit = 1'b0; rd_r = '0; q_r = '0; v_r = '0; mis = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    rs1 = 5'd5;
    rs2 = 5'd7;
    rst = 1'b1;

    //        rdy ren rd_d id com rd_r q_r v_r          mis rs1 rs2 ev1 eq1 ev2 eq2
    // Rename x5 -> 3, then commit with same-cycle bypass.
    vecs.push_back(mk(1, 1, 5, 3, 0, 0, 0, 32'h0, 0, 5, 0, 32'h0, 0, 32'h0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 5, 7, 32'h0, 3, 32'h0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 5, 3, 32'hDEADBEEF, 0, 5, 5,
                      32'hDEADBEEF, 0, 32'hDEADBEEF, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 5, 0, 32'hDEADBEEF, 0, 32'h0, 0));
    // Double rename of x7; commit of the older producer keeps tag 4.
    vecs.push_back(mk(1, 1, 7, 2, 0, 0, 0, 32'h0, 0, 7, 0, 32'h0, 0, 32'h0, 0));
    vecs.push_back(mk(1, 1, 7, 4, 0, 0, 0, 32'h0, 0, 7, 0, 32'h0, 2, 32'h0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 7, 2, 32'h11, 0, 5, 7, 32'hDEADBEEF, 0, 32'h0, 4));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 7, 32'h0, 0, 32'h11, 4));
    // Same-cycle rename and commit to x9: rename wins on Q, value written.
    vecs.push_back(mk(1, 1, 9, 5, 0, 0, 0, 32'h0, 0, 9, 0, 32'h0, 0, 32'h0, 0));
    vecs.push_back(mk(1, 1, 9, 6, 1, 9, 5, 32'h22, 0, 9, 0, 32'h22, 0, 32'h0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 9, 0, 32'h22, 6, 32'h0, 0));
    // Build tags on x1..x3, then misbranch with commit x4 and rename x8.
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 32'h0, 0));
    vecs.push_back(mk(1, 1, 2, 2, 0, 0, 0, 32'h0, 0, 1, 0, 32'h0, 1, 32'h0, 0));
    vecs.push_back(mk(1, 1, 3, 3, 0, 0, 0, 32'h0, 0, 2, 0, 32'h0, 2, 32'h0, 0));
    vecs.push_back(mk(1, 1, 8, 7, 1, 4, 8, 32'h40, 1, 3, 2, 32'h0, 3, 32'h0, 2));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 4, 8, 32'h40, 0, 32'h0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 7, 32'h0, 0, 32'h11, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 3, 9, 32'h0, 0, 32'h22, 0));
    // x0 rename/commit ignored; rdy low freezes a rename and a commit to x6.
    vecs.push_back(mk(1, 1, 0, 9, 1, 0, 9, 32'h99, 0, 0, 0, 32'h0, 0, 32'h0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 6, 32'h0, 0, 32'h0, 0));
    vecs.push_back(mk(0, 1, 6, 10, 1, 6, 1, 32'h66, 0, 6, 0, 32'h0, 0, 32'h0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 6, 0, 32'h0, 0, 32'h0, 0));

    // Reset state.
    #1;
    check("reset_v1", v1, 32'h0);
    check("reset_q1", {27'd0, q1}, 32'h0);
    check("reset_v2", v2, 32'h0);
    check("reset_q2", {27'd0, q2}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) begin
      @(negedge clk);
      rdy = vecs[k].rdy; rename = vecs[k].ren; rd_d = vecs[k].rd_d;
      rob_id = vecs[k].rob_id; commit = vecs[k].com; rd_r = vecs[k].rd_r;
      q_r = vecs[k].q_r; v_r = vecs[k].v_r; mis = vecs[k].mis;
      rs1 = vecs[k].rs1; rs2 = vecs[k].rs2;
      #1;
      check($sformatf("vec%0d_v1", k), v1, vecs[k].ev1);
      check($sformatf("vec%0d_q1", k), {27'd0, q1}, {27'd0, vecs[k].eq1});
      check($sformatf("vec%0d_v2", k), v2, vecs[k].ev2);
      check($sformatf("vec%0d_q2", k), {27'd0, q2}, {27'd0, vecs[k].eq2});
    end

    // Rename x12 -> 5 so reset has a live tag to clear too.
    @(negedge clk);
    idle_inputs();
    rename = 1'b1; rd_d = 5'd12; rob_id = 5'd5;
    @(negedge clk);
    idle_inputs();
    rs1 = 5'd12; rs2 = 5'd5;
    #1;
    check("pre_rst_q1", {27'd0, q1}, 32'd5);
    check("pre_rst_v2", v2, 32'hDEADBEEF);

    // Mid-run asynchronous reset: outputs clear without a clock edge.
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_q1", {27'd0, q1}, 32'h0);
    check("async_rst_v2", v2, 32'h0);
    rs1 = 5'd9; rs2 = 5'd4;
    #1;
    check("async_rst_v1_x9", v1, 32'h0);
    check("async_rst_v2_x4", v2, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_v1_x9", v1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
